// File: rtl/pin_entry_ctrl.sv
// pin_entry_ctrl: keypad PIN entry with compare and timed unlock/err/lockout holds (lockout under `PIN_LOCKOUT_EN).
// Latency: a press acts 3 clk_in edges after the level rises; an enter adds one CHECK cycle before unlock/err.
// Backpressure: none; edges arriving outside ENTRY are dropped, and a level held across a state change never re-fires.
module pin_entry_ctrl #(
  parameter int                   PIN_LEN       = 4,
  parameter logic [PIN_LEN*4-1:0] PIN           = 16'h1234,
  parameter logic [31:0]          UNLOCK_CYCLES = 32'd250_000_000,
  parameter logic [31:0]          ERR_CYCLES    = 32'd50_000_000,
  parameter logic [31:0]          LOCK_CYCLES   = 32'd1_500_000_000,
  parameter int                   MAX_FAIL      = 3
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       btn_inc,
  input  logic       btn_next,
  input  logic       btn_enter,
  output logic [3:0] cur_digit,
  output logic [2:0] digit_cnt,
  output logic       unlock,
  output logic       err,
  output logic       locked_out
);

  // Reject configurations the counters cannot represent.
  if (PIN_LEN < 1 || PIN_LEN > 7 || MAX_FAIL < 1 || MAX_FAIL > 7 ||
      UNLOCK_CYCLES == 32'd0 || ERR_CYCLES == 32'd0 || LOCK_CYCLES == 32'd0) begin : g_bad_cfg
    $error("pin_entry_ctrl: parameter out of range");
  end

  localparam logic [2:0] PIN_LEN_C = 3'(PIN_LEN);

`ifdef PIN_LOCKOUT_EN
  localparam logic [2:0] MAX_FAIL_C = 3'(MAX_FAIL);
  typedef enum logic [2:0] {ST_ENTRY, ST_CHECK, ST_OPEN, ST_FAIL, ST_LOCKOUT} state_t;
`else
  typedef enum logic [1:0] {ST_ENTRY, ST_CHECK, ST_OPEN, ST_FAIL} state_t;
`endif

  state_t                 state, state_nxt;
  logic [3:0]             digit_nxt;
  logic [2:0]             cnt_nxt;
  logic [PIN_LEN*4-1:0]   code_buf, buf_nxt;
  logic [31:0]            timer, timer_nxt;
  logic [2:0]             btn_raw, sync1, sync2, prev;
  logic [2:0]             btn_edge;   // {enter, next, inc}
  logic                   code_match;

`ifdef PIN_LOCKOUT_EN
  logic [2:0]             fail_cnt, fail_nxt;
`endif

  assign btn_raw    = {btn_enter, btn_next, btn_inc};
  assign btn_edge   = sync2 & ~prev;
  assign code_match = (digit_cnt == PIN_LEN_C) && (code_buf == PIN);

  // Two-flop synchronizer plus one history flop per button for rising-edge detection.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // Next-state, digit editing, buffer commit and hold-timer control.
  always_comb begin
    state_nxt = state;
    digit_nxt = cur_digit;
    cnt_nxt   = digit_cnt;
    buf_nxt   = code_buf;
    timer_nxt = timer;
`ifdef PIN_LOCKOUT_EN
    fail_nxt  = fail_cnt;
`endif
    case (state)
      ST_ENTRY: begin
        if (btn_edge[2]) begin
          state_nxt = ST_CHECK;
        end else if (btn_edge[1]) begin
          // A full buffer swallows further commits.
          if (digit_cnt < PIN_LEN_C) begin
            buf_nxt[4*(PIN_LEN-1-int'(digit_cnt)) +: 4] = cur_digit;
            cnt_nxt   = digit_cnt + 3'd1;
            digit_nxt = 4'd0;
          end
        end else if (btn_edge[0]) begin
          digit_nxt = (cur_digit == 4'd9) ? 4'd0 : cur_digit + 4'd1;
        end
      end
      ST_CHECK: begin
        digit_nxt = 4'd0;
        cnt_nxt   = 3'd0;
        buf_nxt   = '0;
        if (code_match) begin
          state_nxt = ST_OPEN;
          timer_nxt = UNLOCK_CYCLES - 32'd1;
`ifdef PIN_LOCKOUT_EN
          fail_nxt  = 3'd0;
`endif
        end else begin
          state_nxt = ST_FAIL;
          timer_nxt = ERR_CYCLES - 32'd1;
`ifdef PIN_LOCKOUT_EN
          fail_nxt  = (fail_cnt == 3'd7) ? 3'd7 : fail_cnt + 3'd1;
`endif
        end
      end
      ST_OPEN: begin
        if (timer == 32'd0) state_nxt = ST_ENTRY;
        else                timer_nxt = timer - 32'd1;
      end
      ST_FAIL: begin
        if (timer == 32'd0) begin
          state_nxt = ST_ENTRY;
`ifdef PIN_LOCKOUT_EN
          if (fail_cnt >= MAX_FAIL_C) begin
            state_nxt = ST_LOCKOUT;
            timer_nxt = LOCK_CYCLES - 32'd1;
          end
`endif
        end else begin
          timer_nxt = timer - 32'd1;
        end
      end
`ifdef PIN_LOCKOUT_EN
      ST_LOCKOUT: begin
        if (timer == 32'd0) begin
          state_nxt = ST_ENTRY;
          fail_nxt  = 3'd0;
        end else begin
          timer_nxt = timer - 32'd1;
        end
      end
`endif
      default: state_nxt = ST_ENTRY;
    endcase
  end

  // State, datapath and registered indicators; indicators follow the next state so they are one-hot by construction.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state     <= ST_ENTRY;
      cur_digit <= 4'd0;
      digit_cnt <= 3'd0;
      code_buf  <= '0;
      timer     <= 32'd0;
      unlock    <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      cur_digit <= digit_nxt;
      digit_cnt <= cnt_nxt;
      code_buf  <= buf_nxt;
      timer     <= timer_nxt;
      unlock    <= (state_nxt == ST_OPEN);
      err       <= (state_nxt == ST_FAIL);
    end
  end

`ifdef PIN_LOCKOUT_EN
  // Consecutive-failure count and lockout indicator.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      fail_cnt   <= 3'd0;
      locked_out <= 1'b0;
    end else begin
      fail_cnt   <= fail_nxt;
      locked_out <= (state_nxt == ST_LOCKOUT);
    end
  end
`else
  assign locked_out = 1'b0;
`endif

endmodule

// File: tb/tb_pin_entry_ctrl.sv
// tb_pin_entry_ctrl: directed plus random button presses against an event-level model of the keypad.
// Latency: expected output changes are scheduled at exact cycles (press + 3, enter + 4, hold lengths).
// Backpressure: none; the model itself drops presses that land while a hold is running.
module tb_pin_entry_ctrl;

  localparam int UNL  = 20;
  localparam int ERRC = 10;
  localparam int LCK  = 50;
  localparam int MAXF = 3;
  localparam logic [15:0] PIN_C = 16'h1234;
`ifdef PIN_LOCKOUT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic       btn_inc = 1'b0, btn_next = 1'b0, btn_enter = 1'b0;
  logic [3:0] cur_digit;
  logic [2:0] digit_cnt;
  logic       unlock, err, locked_out;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int         cyc;
    logic [9:0] vec;
  } exp_t;
  exp_t exp_q[$];

  // Reference model state: the digit being edited, the committed digits, failure streak, busy-until cycle.
  int m_d, m_n, m_fails, m_ready;
  int m_code[4];
  int last_k;

  pin_entry_ctrl #(
    .PIN_LEN      (4),
    .PIN          (16'h1234),
    .UNLOCK_CYCLES(32'd20),
    .ERR_CYCLES   (32'd10),
    .LOCK_CYCLES  (32'd50),
    .MAX_FAIL     (3)
  ) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .btn_inc   (btn_inc),
    .btn_next  (btn_next),
    .btn_enter (btn_enter),
    .cur_digit (cur_digit),
    .digit_cnt (digit_cnt),
    .unlock    (unlock),
    .err       (err),
    .locked_out(locked_out)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  function automatic logic [9:0] mvec(input int d, input int n, input bit u, input bit e, input bit l);
    return {4'(d), 3'(n), u, e, l};
  endfunction

  function automatic void push(input int c, input logic [9:0] v);
    exp_t x;
    x.cyc = c;
    x.vec = v;
    exp_q.push_back(x);
  endfunction

  function automatic int pin_digit(input int i);
    return int'((PIN_C >> (4 * (3 - i))) & 16'hF);
  endfunction

  function automatic void model_reset();
    m_d = 0; m_n = 0; m_fails = 0; m_ready = -1;
    for (int j = 0; j < 4; j++) m_code[j] = 0;
  endfunction

  // Predict the effect of a set of buttons whose rising edge acts at clock edge e.
  function automatic void model_act(input int e, input bit bi, input bit bn, input bit be);
    bit match;
    if (e <= m_ready) return;
    if (be) begin
      match = (m_n == 4);
      for (int j = 0; j < 4; j++) if (m_code[j] != pin_digit(j)) match = 1'b0;
      m_d = 0; m_n = 0;
      for (int j = 0; j < 4; j++) m_code[j] = 0;
      if (match) begin
        push(e + 1, mvec(0, 0, 1, 0, 0));
        push(e + 1 + UNL, mvec(0, 0, 0, 0, 0));
        m_ready = e + 1 + UNL;
        m_fails = 0;
      end else begin
        push(e + 1, mvec(0, 0, 0, 1, 0));
        if (m_fails < 7) m_fails++;
        if (LOCK_EN && m_fails >= MAXF) begin
          push(e + 1 + ERRC, mvec(0, 0, 0, 0, 1));
          push(e + 1 + ERRC + LCK, mvec(0, 0, 0, 0, 0));
          m_ready = e + 1 + ERRC + LCK;
          m_fails = 0;
        end else begin
          push(e + 1 + ERRC, mvec(0, 0, 0, 0, 0));
          m_ready = e + 1 + ERRC;
        end
      end
    end else if (bn) begin
      if (m_n < 4) begin
        m_code[m_n] = m_d;
        m_n++;
        m_d = 0;
        push(e, mvec(m_d, m_n, 0, 0, 0));
      end
    end else if (bi) begin
      m_d = (m_d + 1) % 10;
      push(e, mvec(m_d, m_n, 0, 0, 0));
    end
  endfunction

  // One press: raise the chosen buttons together, hold, release, then idle.
  task automatic op(input bit bi, input bit bn, input bit be, input int hold, input int gap);
    @(posedge clk_in);
    #1;
    last_k = cyc;
    model_act(cyc + 3, bi, bn, be);
    btn_inc = bi; btn_next = bn; btn_enter = be;
    repeat (hold) @(posedge clk_in);
    #1;
    btn_inc = 1'b0; btn_next = 1'b0; btn_enter = 1'b0;
    repeat (gap) @(posedge clk_in);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_in);
  endtask

  task automatic enter_code(input int n, input int d0, input int d1, input int d2, input int d3);
    int dg[4];
    int c;
    dg[0] = d0; dg[1] = d1; dg[2] = d2; dg[3] = d3;
    for (int i = 0; i < n; i++) begin
      c = (dg[i] - m_d + 10) % 10;
      repeat (c) op(1'b1, 1'b0, 1'b0, 1, 1);
      op(1'b0, 1'b1, 1'b0, 1, 1);
    end
    op(1'b0, 1'b0, 1'b1, 1, 1);
  endtask

  // Monitor: every change of the output vector must match the next scheduled change, value and cycle.
  logic [9:0] mon_prev = '0;
  logic [9:0] mon_cur;
  exp_t       mon_e;
  always @(negedge clk_in) begin
    mon_cur = {cur_digit, digit_cnt, unlock, err, locked_out};
    if (rst) begin
      mon_prev = mon_cur;
    end else begin
      total++;
      if ($countones({unlock, err, locked_out}) > 1) begin
        bad++;
        $display("FAIL onehot cyc=%0d got u/e/l=%b%b%b required at most one high", cyc, unlock, err, locked_out);
      end
      if (mon_cur !== mon_prev) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_change cyc=%0d got=%h required=no change", cyc, mon_cur);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.cyc != cyc || mon_e.vec !== mon_cur) begin
            bad++;
            $display("FAIL change got=%h@%0d required=%h@%0d", mon_cur, cyc, mon_e.vec, mon_e.cyc);
          end
        end
        mon_prev = mon_cur;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog cyc=%0d required=finish before time limit", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    model_reset();
    rst = 1'b1;
    idle(3);
    #1;
    total++;
    if ({cur_digit, digit_cnt, unlock, err, locked_out} !== 10'd0) begin
      bad++;
      $display("FAIL reset_state got=%h required=000", {cur_digit, digit_cnt, unlock, err, locked_out});
    end
    rst = 1'b0;
    idle(3);

    // Correct code unlocks.
    enter_code(4, 1, 2, 3, 4);
    idle(30);

    // Ten increments wrap back to zero.
    repeat (10) op(1'b1, 1'b0, 1'b0, 1, 1);
    idle(3);
    total++;
    if (cur_digit !== 4'd0) begin
      bad++;
      $display("FAIL wrap got=%0d required=0", cur_digit);
    end

    // Short code is rejected.
    enter_code(3, 1, 2, 3, 0);
    idle(20);

    // Three wrong codes; presses during the final hold.
    repeat (3) begin
      repeat (4) op(1'b0, 1'b1, 1'b0, 1, 1);
      op(1'b0, 1'b0, 1'b1, 1, 1);
      idle(2);
    end
    idle(12);
    op(1'b1, 1'b0, 1'b0, 1, 2);
    op(1'b0, 1'b1, 1'b0, 1, 2);
    op(1'b1, 1'b0, 1'b0, 2, 2);
    idle(70);
    enter_code(4, 1, 2, 3, 4);
    idle(30);

    // inc and next rising together: only the commit happens.
    repeat (5) op(1'b1, 1'b0, 1'b0, 1, 1);
    op(1'b1, 1'b1, 1'b0, 1, 1);
    idle(3);
    total++;
    if (digit_cnt !== 3'd1 || cur_digit !== 4'd0) begin
      bad++;
      $display("FAIL simul got cnt=%0d dig=%0d required cnt=1 dig=0", digit_cnt, cur_digit);
    end
    op(1'b0, 1'b0, 1'b1, 1, 1);
    idle(20);

    // Long hold counts once.
    op(1'b1, 1'b0, 1'b0, 1000, 1);
    idle(3);
    total++;
    if (cur_digit !== 4'(m_d)) begin
      bad++;
      $display("FAIL held got=%0d required=%0d", cur_digit, m_d);
    end

    // Reset in the fifth unlock cycle.
    enter_code(4, 1, 2, 3, 4);
    #1;
    while (cyc < last_k + 8) begin
      @(posedge clk_in);
      #1;
    end
    total++;
    if (unlock !== 1'b1) begin
      bad++;
      $display("FAIL unlock_before_reset got=%b required=1", unlock);
    end
    rst = 1'b1;
    exp_q.delete();
    model_reset();
    #1;
    total++;
    if ({cur_digit, digit_cnt, unlock, err, locked_out} !== 10'd0) begin
      bad++;
      $display("FAIL reset_mid_open got=%h required=000", {cur_digit, digit_cnt, unlock, err, locked_out});
    end
    idle(2);
    #1;
    rst = 1'b0;
    idle(2);
    enter_code(4, 1, 2, 3, 4);
    idle(30);

    // Random presses, with occasional full correct entries.
    repeat (200) begin
      r = $urandom_range(0, 19);
      if (r == 0)       enter_code(4, 1, 2, 3, 4);
      else if (r < 9)   op(1'b1, 1'b0, 1'b0, $urandom_range(1, 6), $urandom_range(1, 5));
      else if (r < 14)  op(1'b0, 1'b1, 1'b0, $urandom_range(1, 6), $urandom_range(1, 5));
      else if (r < 16)  op(1'b0, 1'b0, 1'b1, $urandom_range(1, 6), $urandom_range(1, 5));
      else              op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           $urandom_range(1, 6), $urandom_range(1, 5));
    end
    idle(100);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover got=%0d pending changes required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
